urem_ne0_checker: RTL and testbench



---
 rtl/urem_ne0_checker.sv | 122 ++++++++++++
 tb/tb_urem_ne0_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/urem_ne0_checker.sv
// rtl/urem_ne0_checker.sv - bit-serial unsigned remainder with witness check for "x urem y != 0"
module urem_ne0_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             claim,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] remainder,
    output logic             rem_nz,
    output logic             claim_ok,
    output logic [CNT_W-1:0] err_count
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             claim_q;
    logic [WIDTH-1:0] r;
    logic [IW-1:0]    iter;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] done_rem;
    logic             last_iter;
    logic             div_zero;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // After restoration r < divisor, so the stored partial remainder needs only WIDTH bits.
    always_comb begin
        r_shift   = {r, dvd[WIDTH-1]};
        r_next    = r_shift[WIDTH-1:0];
        if (r_shift >= {1'b0, dvs}) begin
            r_next = WIDTH'(r_shift - {1'b0, dvs});
        end
        last_iter = (iter == IW'(WIDTH - 1));
        div_zero  = (dvs == '0);
        done_rem  = div_zero ? dvd : r_next;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = DIV;
            DIV:     if (div_zero || last_iter) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            dvs       <= '0;
            claim_q   <= 1'b0;
            r         <= '0;
            iter      <= '0;
            remainder <= '0;
            rem_nz    <= 1'b0;
            claim_ok  <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd     <= dividend;
                        dvs     <= divisor;
                        claim_q <= claim;
                        r       <= '0;
                        iter    <= '0;
                    end
                end
                DIV: begin
                    // A zero divisor spends this cycle only to resolve; no iteration runs.
                    if (!div_zero) begin
                        r    <= r_next;
                        dvd  <= {dvd[WIDTH-2:0], 1'b0};
                        iter <= iter + 1'b1;
                    end
                    if (div_zero || last_iter) begin
                        remainder <= done_rem;
                        rem_nz    <= |done_rem;
                        claim_ok  <= (claim_q == |done_rem);
                    end
                end
                DONE: begin
                    if (out_ready && !claim_ok && (err_count != {CNT_W{1'b1}})) begin
                        err_count <= err_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_urem_ne0_checker.sv
// tb/tb_urem_ne0_checker.sv - randomized self-checking bench for urem_ne0_checker
module tb_urem_ne0_checker;

    localparam int W  = 4;
    localparam int CW = 2;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          claim;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  remainder;
    logic          rem_nz;
    logic          claim_ok;
    logic [CW-1:0] err_count;

    int n_checks;
    int n_pass;
    int exp_err;

    urem_ne0_checker #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .claim     (claim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .remainder (remainder),
        .rem_nz    (rem_nz),
        .claim_ok  (claim_ok),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_remainder"}, 32'(remainder), 0);
        check({tag, "_rem_nz"},    32'(rem_nz),    0);
        check({tag, "_claim_ok"},  32'(claim_ok),  0);
        check({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset");
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: SMT-LIB urem (x urem 0 = x), latency WIDTH or 1 for a zero divisor.
    task automatic do_op(input int a, input int b, input bit c, input int hold, input bit garbage);
        int  exp_rem;
        int  exp_lat;
        int  lat;
        bit  exp_nz;
        bit  exp_ok;
        bit  seen;
        logic [W-1:0] r0;
        exp_rem = (b == 0) ? a : a % b;
        exp_lat = (b == 0) ? 1 : W;
        exp_nz  = (exp_rem != 0);
        exp_ok  = (c == exp_nz);

        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        claim    = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        claim    = 1'($urandom);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = out_valid;
        end
        check("latency",   32'(lat),       32'(exp_lat));
        check("remainder", 32'(remainder), 32'(exp_rem));
        check("rem_nz",    32'(rem_nz),    32'(exp_nz));
        check("claim_ok",  32'(claim_ok),  32'(exp_ok));
        check("in_ready_done", 32'(in_ready), 0);

        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            if (garbage) begin
                in_valid = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
                claim    = 1'($urandom);
            end
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_in_ready",  32'(in_ready),  0);
            check("hold_remainder", 32'(remainder), 32'(r0));
            check("hold_claim_ok",  32'(claim_ok),  32'(exp_ok));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        if (!exp_ok && exp_err < ERR_MAX) exp_err++;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after", 32'(in_ready),  1);
        check("out_valid_after", 32'(out_valid), 0);
        check("err_count",      32'(err_count), 32'(exp_err));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_err   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        claim     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        do_op(13, 5, 1'b1, 0, 1'b0);
        do_op(8, 4, 1'b0, 0, 1'b0);
        do_op(8, 4, 1'b1, 0, 1'b0);
        do_op(9, 0, 1'b1, 0, 1'b0);
        do_op(15, 1, 1'b0, 10, 1'b1);

        do_reset();
        for (int i = 0; i < 5; i++) do_op(7, 3, 1'b0, 0, 1'b0);

        // Reset while the divider is in its second iteration.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = W'(13);
        divisor  = W'(5);
        claim    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midop");
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(14, 3, 1'b1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            do_op(a, b, 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
